// File: rtl/multdiv_hilo_ctrl.sv
// rtl/multdiv_hilo_ctrl.sv - multiply/divide sequencer and HI/LO register file
module multdiv_hilo_ctrl #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div_zero,
  output logic        multOp,
  output logic        divOp,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, MULT, DIV, CAP_M, CAP_D} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        // mult wins a simultaneous request; the divide strobe is simply dropped
        if (start_mult) begin
          state_nxt = MULT;
          cnt_nxt   = '0;
        end else if (start_div) begin
          state_nxt = DIV;
          cnt_nxt   = '0;
        end
      end
      MULT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == MULT_LAST) state_nxt = CAP_M;
      end
      DIV: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == DIV_LAST) state_nxt = CAP_D;
      end
      CAP_M:   state_nxt = IDLE;
      CAP_D:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Op-enables stay high through the capture cycle so the unit holds its result.
  assign multOp = (state == MULT) || (state == CAP_M);
  assign divOp  = (state == DIV)  || (state == CAP_D);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= (state == CAP_M) || (state == CAP_D);
      div_by_zero <= (state == CAP_D) && div_zero;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
        end
        CAP_M: begin
          hi <= mult_hi;
          lo <= mult_lo;
        end
        CAP_D: begin
          if (!div_zero) begin
            hi <= div_hi;
            lo <= div_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_hilo_ctrl.sv
// tb/tb_multdiv_hilo_ctrl.sv - scoreboard bench for multdiv_hilo_ctrl
module tb_multdiv_hilo_ctrl;

  localparam int UNIT_CYCLES = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_mult = 1'b0, start_div = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic        div_zero;
  logic        multOp, divOp, busy, done, div_by_zero;
  logic [31:0] hi, lo;

  logic [31:0] op_a = '0, op_b = 32'd1;
  int          mcnt = 0, dcnt = 0, cyc = 0;
  int          vectors = 0, miscompares = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          due;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        prev_done = 1'b0;

  multdiv_hilo_ctrl #(.MULT_CYCLES(UNIT_CYCLES), .DIV_CYCLES(UNIT_CYCLES)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_hi(div_hi), .div_lo(div_lo), .div_zero(div_zero), .multOp(multOp), .divOp(divOp),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unit stand-in: result is only valid after 32 enabled edges, junk otherwise.
  always @(posedge clk) begin
    mcnt <= multOp ? mcnt + 1 : 0;
    dcnt <= divOp ? dcnt + 1 : 0;
  end

  longint      prod;
  logic [31:0] quo, rem;
  always_comb begin
    prod = longint'($signed(op_a)) * longint'($signed(op_b));
    quo  = (op_b != 0) ? op_a / op_b : 32'h0;
    rem  = (op_b != 0) ? op_a % op_b : 32'h0;
  end
  assign div_zero = (op_b == 32'h0);
  assign mult_hi  = (mcnt >= UNIT_CYCLES) ? prod[63:32] : ~prod[63:32];
  assign mult_lo  = (mcnt >= UNIT_CYCLES) ? prod[31:0]  : ~prod[31:0];
  assign div_hi   = (dcnt >= UNIT_CYCLES && !div_zero) ? rem : 32'hDEADBEEF;
  assign div_lo   = (dcnt >= UNIT_CYCLES && !div_zero) ? quo : 32'hFEEDFACE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result_hi", hi, e.hi);
          check("result_lo", lo, e.lo);
          check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
          check("done_latency", cyc, e.due);
        end
        if (prev_done) check("done_twice", 32'd1, 32'd0);
      end else if (div_by_zero) begin
        check("dbz_without_done", 32'd1, 32'd0);
      end
    end
    prev_done <= done;
  end

  // kind: 0 write only, 1 mult, 2 div, 3 both strobes. Called at a negedge with DUT idle.
  task automatic issue(input int kind, input logic [31:0] a, input logic [31:0] b,
                       input logic hw, input logic lw, input logic [31:0] wd,
                       input bit inject, output int on_cnt);
    exp_t   e;
    longint p;
    int     n;
    on_cnt = 0;
    check("idle_op_enable", {31'b0, multOp | divOp}, 32'd0);
    op_a = a; op_b = b; hi_we = hw; lo_we = lw; wdata = wd;
    start_mult = (kind == 1 || kind == 3);
    start_div  = (kind == 2 || kind == 3);
    if (hw) m_hi = wd;
    if (lw) m_lo = wd;
    e.dbz = 1'b0;
    if (kind == 1 || kind == 3) begin
      p = longint'($signed(a)) * longint'($signed(b));
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (kind == 2) begin
      if (b == 0) e.dbz = 1'b1;
      else begin
        m_hi = a % b;
        m_lo = a / b;
      end
    end
    if (kind != 0) begin
      e.hi = m_hi; e.lo = m_lo; e.due = cyc + 34;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start_mult = 0; start_div = 0; hi_we = 0; lo_we = 0;
    if (kind == 0) begin
      @(negedge clk);
      check("write_hi", hi, m_hi);
      check("write_lo", lo, m_lo);
      return;
    end
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (multOp | divOp) on_cnt++;
      if (kind != 2) check("no_divOp_in_mult", {31'b0, divOp}, 32'd0);
      if (!busy) break;
      if (inject && n == 5) begin
        start_div = 1; hi_we = 1; lo_we = 1; wdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        start_div = 0; hi_we = 0; lo_we = 0;
      end
    end
    if (busy) check("op_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_ops", {30'b0, multOp, divOp}, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);

    // MTHI/MTLO in idle
    issue(0, 0, 1, 1, 1, 32'h12345678, 0, cnt);

    // reset mid-multiply aborts without writing HI/LO
    op_a = 32'd5; op_b = 32'd9; start_mult = 1;
    @(posedge clk); #1 start_mult = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("pre_reset_multOp", {31'b0, multOp}, 1);
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    sb.delete();
    m_hi = 0; m_lo = 0;
    @(negedge clk);
    check("abort_multOp", {31'b0, multOp}, 0);
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    repeat (40) @(negedge clk);

    issue(1, 32'd7, 32'hFFFFFFFD, 0, 0, 0, 0, cnt);
    check("mult_enable_cycles", cnt, 33);

    issue(1, 32'h00010000, 32'h00010000, 0, 0, 0, 0, cnt);
    issue(1, $urandom, $urandom, 0, 0, 0, 0, cnt);
    check("b2b_enable_cycles", cnt, 33);

    issue(0, 0, 1, 1, 0, 32'hAAAA0000, 0, cnt);
    issue(2, 32'd100, 32'd0, 0, 0, 0, 0, cnt);
    check("div_enable_cycles", cnt, 33);

    issue(3, 32'h11111111, 32'h3, 0, 0, 0, 1, cnt);
    @(negedge clk);
    check("ignored_write_hi", hi, m_hi);
    issue(2, 32'd1000, 32'd7, 0, 0, 0, 0, cnt);

    for (int i = 0; i < 30; i++) begin
      int          kind;
      logic [31:0] b;
      kind = $urandom_range(0, 2);
      b = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      issue(kind, $urandom, b, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom, $urandom_range(0, 3) == 0, cnt);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
